// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - sequential signed/unsigned multiply/divide unit feeding HI/LO
// One shift-add (multiply) or restore-subtract (divide) step per clock on magnitudes; sign fixed up at the end.
module muldiv_seq #(
  parameter int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   count;
  logic [1:0]         op_r;
  logic [WIDTH-1:0]   a_abs_r, b_abs_r;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   rem;
  logic               neg_q, neg_r, zero_r;

  logic               signed_op, a_neg, b_neg, b_zero;
  logic [WIDTH-1:0]   a_abs, b_abs;

  always_comb begin
    signed_op = ~op[0];
    a_neg     = signed_op & a[WIDTH-1];
    b_neg     = signed_op & b[WIDTH-1];
    a_abs     = a_neg ? -a : a;
    b_abs     = b_neg ? -b : b;
    b_zero    = op[1] & (b == '0);
  end

  // acc holds {partial product, multiplier} for MULT, and the dividend/quotient shift register in its low half for DIV
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem_nxt;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  always_comb begin
    mul_sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_abs_r} : '0);
    mul_next    = {mul_sum, acc[WIDTH-1:1]};
    div_shift   = {rem, acc[WIDTH-1]};
    div_ge      = (div_shift >= {1'b0, b_abs_r});
    div_rem_nxt = div_ge ? WIDTH'(div_shift - {1'b0, b_abs_r}) : div_shift[WIDTH-1:0];
    prod_fix    = neg_q ? -acc : acc;
    quo_fix     = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix     = neg_r ? -rem : rem;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = b_zero ? S_FIX : S_RUN;
      S_RUN:   if (count == CNT_W'(WIDTH - 1)) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      count    <= '0;
      op_r     <= '0;
      a_abs_r  <= '0;
      b_abs_r  <= '0;
      acc      <= '0;
      rem      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      zero_r   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            op_r     <= op;
            a_abs_r  <= a_abs;
            b_abs_r  <= b_abs;
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            zero_r   <= b_zero;
            div_zero <= 1'b0;
            count    <= '0;
            busy     <= 1'b1;
            rem      <= '0;
            acc      <= {{WIDTH{1'b0}}, (op[1] ? a_abs : b_abs)};
          end
        end
        S_RUN: begin
          count <= count + CNT_W'(1);
          if (op_r[1]) begin
            rem             <= div_rem_nxt;
            acc[WIDTH-1:0]  <= {acc[WIDTH-2:0], div_ge};
          end else begin
            acc <= mul_next;
          end
        end
        S_FIX: begin
          done <= 1'b1;
          busy <= 1'b0;
          if (zero_r) begin
            div_zero <= 1'b1;
          end else if (op_r[1]) begin
            lo <= quo_fix;
            hi <= rem_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - self-checking bench for muldiv_seq at WIDTH=32 and WIDTH=8
// Expected results come from plain integer arithmetic on sign-extended operands.
module tb_muldiv_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst32, s_start, s_busy, s_done, s_dz;
  logic [1:0]  s_op;
  logic [31:0] s_a, s_b, s_hi, s_lo;

  logic        rst8, e_start, e_busy, e_done, e_dz;
  logic [1:0]  e_op;
  logic [7:0]  e_a, e_b, e_hi, e_lo;

  int checks = 0;
  int failures = 0;

  logic [63:0] exp32_hi, exp32_lo, exp8_hi, exp8_lo;

  muldiv_seq #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(rst32), .start(s_start), .op(s_op), .a(s_a), .b(s_b),
    .busy(s_busy), .done(s_done), .div_zero(s_dz), .hi(s_hi), .lo(s_lo)
  );

  muldiv_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(rst8), .start(e_start), .op(e_op), .a(e_a), .b(e_b),
    .busy(e_busy), .done(e_done), .div_zero(e_dz), .hi(e_hi), .lo(e_lo)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Result of one operation on w-bit operands; on divide-by-zero hi/lo keep the previous values
  task automatic ref_model(input int w, input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] phi, input logic [63:0] plo,
                           output logic [63:0] hi, output logic [63:0] lo, output bit dz, output int lat);
    logic [63:0] mask, ua, ub, uprod;
    longint sa, sb, prod, q, r;
    mask = (64'd1 << w) - 64'd1;
    ua = a & mask;
    ub = b & mask;
    sa = $signed(ua << (64 - w)) >>> (64 - w);
    sb = $signed(ub << (64 - w)) >>> (64 - w);
    hi = phi; lo = plo; dz = 0; lat = w + 2;
    case (op)
      2'd0: begin prod = sa * sb; hi = (prod >> w) & mask; lo = prod & mask; end
      2'd1: begin uprod = ua * ub; hi = (uprod >> w) & mask; lo = uprod & mask; end
      default: begin
        if (ub == 0) begin
          dz = 1; lat = 2;
        end else if (op == 2'd2) begin
          q = sa / sb; r = sa % sb;
          lo = q & mask; hi = r & mask;
        end else begin
          lo = (ua / ub) & mask; hi = (ua % ub) & mask;
        end
      end
    endcase
  endtask

  task automatic op32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit inject);
    int n, lat;
    logic [63:0] eh, el;
    bit dz;
    ref_model(32, op, {32'b0, a}, {32'b0, b}, exp32_hi, exp32_lo, eh, el, dz, lat);
    @(negedge clk);
    s_start = 1'b1; s_op = op; s_a = a; s_b = b;
    @(posedge clk); #1;
    s_start = 1'b0;
    check("w32_busy_accept", s_busy, 1);
    check("w32_dz_clear", s_dz, 0);
    n = 1;
    while (!s_done && n < 200) begin
      @(negedge clk);
      if (inject) begin
        s_start = (n == 6);
        s_op = 2'($urandom); s_a = $urandom; s_b = $urandom;
      end
      @(posedge clk); #1;
      n++;
    end
    s_start = 1'b0;
    check("w32_latency", n, lat);
    check("w32_hi", s_hi, eh);
    check("w32_lo", s_lo, el);
    check("w32_div_zero", s_dz, dz);
    check("w32_busy_done", s_busy, 0);
    exp32_hi = eh; exp32_lo = el;
  endtask

  // start stays high throughout; operand inputs carry junk while busy
  task automatic op8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    int n, lat;
    logic [63:0] eh, el;
    bit dz;
    ref_model(8, op, {56'b0, a}, {56'b0, b}, exp8_hi, exp8_lo, eh, el, dz, lat);
    @(negedge clk);
    e_start = 1'b1; e_op = op; e_a = a; e_b = b;
    @(posedge clk); #1;
    check("w8_busy_accept", e_busy, 1);
    n = 1;
    while (!e_done && n < 50) begin
      @(negedge clk);
      e_op = 2'($urandom); e_a = 8'($urandom); e_b = 8'($urandom);
      @(posedge clk); #1;
      n++;
    end
    check("w8_latency", n, lat);
    check("w8_hi", e_hi, eh);
    check("w8_lo", e_lo, el);
    check("w8_div_zero", e_dz, dz);
    check("w8_busy_done", e_busy, 0);
    exp8_hi = eh; exp8_lo = el;
  endtask

  initial begin
    bit saw_done;
    logic [31:0] rb;
    logic [7:0]  eb;
    rst32 = 1'b1; rst8 = 1'b1;
    s_start = 1'b0; s_op = '0; s_a = '0; s_b = '0;
    e_start = 1'b0; e_op = '0; e_a = '0; e_b = '0;
    exp32_hi = 0; exp32_lo = 0; exp8_hi = 0; exp8_lo = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", s_busy, 0);
    check("rst_done", s_done, 0);
    check("rst_dz", s_dz, 0);
    check("rst_hi", s_hi, 0);
    check("rst_lo", s_lo, 0);
    @(negedge clk);
    rst32 = 1'b0; rst8 = 1'b0;

    op32(2'd0, 32'hFFFFFFFD, 32'd7, 0);
    check("mult_neg3x7_hi", s_hi, 32'hFFFFFFFF);
    check("mult_neg3x7_lo", s_lo, 32'hFFFFFFEB);
    op32(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    check("multu_max_hi", s_hi, 32'hFFFFFFFE);
    check("multu_max_lo", s_lo, 32'h00000001);
    op32(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    check("mult_m1m1_hi", s_hi, 32'h0);
    check("mult_m1m1_lo", s_lo, 32'h1);
    op32(2'd2, 32'hFFFFFFF9, 32'd2, 0);
    check("div_neg7_lo", s_lo, 32'hFFFFFFFD);
    check("div_neg7_hi", s_hi, 32'hFFFFFFFF);
    op32(2'd3, 32'd100, 32'd7, 0);
    check("divu_100_7_lo", s_lo, 32'd14);
    check("divu_100_7_hi", s_hi, 32'd2);
    op32(2'd2, 32'h80000000, 32'hFFFFFFFF, 0);
    check("div_ovf_lo", s_lo, 32'h80000000);
    check("div_ovf_hi", s_hi, 32'h0);
    check("div_ovf_dz", s_dz, 0);
    op32(2'd3, 32'd100, 32'd7, 0);
    op32(2'd3, 32'd55, 32'd0, 0);
    check("divz_dz", s_dz, 1);
    check("divz_hi_hold", s_hi, 32'd2);
    check("divz_lo_hold", s_lo, 32'd14);
    op32(2'd1, 32'd3, 32'd5, 0);
    check("multu_3x5_lo", s_lo, 32'd15);
    check("multu_3x5_hi", s_hi, 32'd0);
    op32(2'd1, 32'd1234, 32'd5678, 1);
    check("ignore_start_lo", s_lo, 32'h006AE9BC);
    check("ignore_start_hi", s_hi, 32'h0);

    // reset in the middle of RUN discards the operation
    @(negedge clk);
    s_start = 1'b1; s_op = 2'd1; s_a = 32'hDEADBEEF; s_b = 32'h12345678;
    @(posedge clk); #1;
    s_start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst32 = 1'b1;
    @(posedge clk); #1;
    check("midrst_busy", s_busy, 0);
    check("midrst_done", s_done, 0);
    check("midrst_hi", s_hi, 0);
    check("midrst_lo", s_lo, 0);
    check("midrst_dz", s_dz, 0);
    @(negedge clk);
    rst32 = 1'b0;
    saw_done = 0;
    repeat (50) begin
      @(posedge clk); #1;
      if (s_done) saw_done = 1;
    end
    check("midrst_no_done", saw_done, 0);
    exp32_hi = 0; exp32_lo = 0;

    for (int i = 0; i < 200; i++) begin
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      op32(2'($urandom), $urandom, rb, 0);
    end

    op8(2'd0, 8'h80, 8'h80);
    check("w8_mult_80_hi", e_hi, 8'h40);
    check("w8_mult_80_lo", e_lo, 8'h00);
    op8(2'd2, 8'h81, 8'h03);
    check("w8_div_81_lo", e_lo, 8'hD6);
    check("w8_div_81_hi", e_hi, 8'hFF);
    for (int i = 0; i < 4000; i++) begin
      eb = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
      op8(2'(i % 4), 8'($urandom), eb);
    end
    e_start = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
